sr_mdu: RTL and testbench
=========================

SR_MDU -- requirements
Module: sr_mdu

Iterative unsigned multiply/divide unit, parallel to the single-cycle ALU; consumes the same srcA/srcB operands and feeds its result to the writeback mux.

Interface
REQ-001 Parameter: none; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 oper  input  2  operation code: 00 MUL (low 32 bits), 01 MULHU (high 32 bits), 10 DIVU (quotient), 11 REMU (remainder).
REQ-006 srcA  input  32  multiplicand / dividend.
REQ-007 srcB  input  32  multiplier / divisor.
REQ-008 busy  output  1  high in RUN state.
REQ-009 done  output  1  one-cycle pulse; result valid in this cycle.
REQ-010 result  output  32  operation result; held stable from done until the next accepted start.
REQ-011 zero  output  1  (result == 0), combinational from result.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN on start, RUN->DONE after 32 iterations, DONE->IDLE unconditionally.
REQ-013 On accepted start, srcA, srcB and oper SHALL be latched; operand changes afterwards SHALL NOT affect the operation.
REQ-014 A 5-bit iteration counter SHALL clear on accept, increment once per RUN cycle, and exit RUN after the cycle in which it equals 31.
REQ-015 Timing: start high in cycle 0 -> busy high in cycles 1..32 -> done high in cycle 33 only; fixed 33-cycle latency for all opers.
REQ-016 Multiply SHALL be shift-add on a 64-bit product register, 1 bit per cycle; MUL returns product[31:0], MULHU returns product[63:32].
REQ-017 Divide SHALL be restoring, 1 quotient bit per cycle, with a 33-bit partial remainder; DIVU returns the quotient and REMU the remainder.
REQ-018 Divisor 0 SHALL NOT be special-cased; the algorithm SHALL naturally yield quotient 0xFFFFFFFF and remainder = dividend (RISC-V semantics), with the same latency.
REQ-019 start in RUN or DONE SHALL be ignored (not queued); the earliest next accept is the IDLE cycle following DONE (cycle 34).
REQ-020 result SHALL update only on the transition into DONE and SHALL hold its value in IDLE.
REQ-021 done and busy SHALL never be high in the same cycle.

Reset
REQ-022 While rst_n=0 at a clock edge: state=IDLE, counter=0, busy=0, done=0, result=0 (so zero=1), internal registers cleared.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; start sampled in the first cycle after rst_n rises SHALL be accepted normally.

Verification
REQ-024 MUL 7 x 6 -> done in cycle 33, result=0x0000002A, zero=0; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE.
REQ-025 DIVU 100/7 -> result=14; REMU 100/7 -> result=2; REMU 5/9 -> result=5.
REQ-026 DIVU 0x12345678/0 -> result=0xFFFFFFFF; REMU 0x12345678/0 -> result=0x12345678; latency still 33.
REQ-027 start re-pulsed in cycles 5 and 33 with different operands -> ignored; first result unchanged, single done pulse; start in cycle 34 accepted.
REQ-028 rst_n low in cycle 10 of a DIVU -> no done, busy=0, result=0 next cycle; a new MUL 3 x 3 after reset gives result=9.
REQ-029 srcA/srcB toggled every cycle during RUN -> result equals the value computed from the operands latched at accept.

Source files
------------

// File: rtl/sr_mdu.sv
// Iterative 32-bit unsigned multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle with a fixed 33-cycle start-to-done latency.
module sr_mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  oper,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [1:0]     oper_q;
    logic [W-1:0]   opb;
    logic [W-1:0]   hi, hi_nxt;
    logic [W-1:0]   lo, lo_nxt;
    logic [W-1:0]   result_nxt;
    logic           busy_nxt, done_nxt, load;
    logic [W:0]     mul_sum, rem_sh, rem_sub;
    logic           rem_ge;

    // hi/lo form the 64-bit product register for multiply, and the partial
    // remainder / dividend-quotient shift pair for divide; opb holds the
    // multiplicand or divisor.
    always_comb begin
        mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? opb : '0)};
        rem_sh  = {hi, lo[W-1]};
        rem_sub = rem_sh - {1'b0, opb};
        rem_ge  = (rem_sh >= {1'b0, opb});
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi;
        lo_nxt     = lo;
        result_nxt = result;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    load      = 1'b1;
                    hi_nxt    = '0;
                    lo_nxt    = oper[1] ? srcA : srcB;
                end
            end
            RUN: begin
                busy_nxt = 1'b1;
                cnt_nxt  = CW'(cnt + 1'b1);
                if (oper_q[1]) begin
                    hi_nxt = rem_ge ? W'(rem_sub) : W'(rem_sh);
                    lo_nxt = {lo[W-2:0], rem_ge};
                end else begin
                    hi_nxt = mul_sum[W:1];
                    lo_nxt = {mul_sum[0], lo[W-1:1]};
                end
                if (cnt == CW'(W - 1)) begin
                    state_nxt  = DONE;
                    busy_nxt   = 1'b0;
                    done_nxt   = 1'b1;
                    // MULHU/REMU come from the upper half, MUL/DIVU from the lower
                    result_nxt = oper_q[0] ? hi_nxt : lo_nxt;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            oper_q <= '0;
            opb    <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            result <= result_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            if (load) begin
                oper_q <= oper;
                opb    <= oper[1] ? srcB : srcA;
            end
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_sr_mdu.sv
// Self-checking bench for sr_mdu: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_sr_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  oper;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int total = 0;
    int bad   = 0;

    sr_mdu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .oper   (oper),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an operation in the current cycle (cycle 0) and check busy/done over
    // cycles 1..34. toggle scrambles inputs during RUN; pulses re-asserts start
    // with other operands in cycles 5 and 33, which must be ignored.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit toggle, input bit pulses);
        logic [31:0] exp;
        exp   = model(op, a, b);
        start = 1'b1;
        oper  = op;
        srcA  = a;
        srcB  = b;
        for (int c = 1; c <= 33; c++) begin
            tick();
            start = 1'b0;
            if (toggle) begin
                srcA = $urandom;
                srcB = $urandom;
                oper = 2'($urandom);
            end
            if (pulses && (c == 5 || c == 33)) begin
                start = 1'b1;
                oper  = ~op;
                srcA  = ~a;
                srcB  = $urandom;
            end
            check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c <= 32));
            check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == 33));
        end
        check({tag, " result"}, result, exp);
        check({tag, " zero"}, 32'(zero), 32'(exp == 32'd0));
        tick();
        start = 1'b0;
        check({tag, " done c34"}, 32'(done), 32'd0);
        check({tag, " busy c34"}, 32'(busy), 32'd0);
        check({tag, " hold c34"}, result, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        oper  = 2'd0;
        srcA  = '0;
        srcB  = '0;
        tick();
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        check("rst zero", 32'(zero), 32'd1);
        rst_n = 1'b1;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        run_op("mul7x6", 2'd0, 32'd7, 32'd6, 1'b0, 1'b0);
        check("mul7x6 literal", result, 32'h0000_002A);
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("mulhu_ff literal", result, 32'hFFFF_FFFE);
        run_op("divu100_7", 2'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        check("divu100_7 literal", result, 32'd14);
        run_op("remu100_7", 2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        check("remu100_7 literal", result, 32'd2);
        run_op("remu5_9", 2'd3, 32'd5, 32'd9, 1'b0, 1'b0);
        check("remu5_9 literal", result, 32'd5);
        run_op("divu_by0", 2'd2, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        check("divu_by0 literal", result, 32'hFFFF_FFFF);
        run_op("remu_by0", 2'd3, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        check("remu_by0 literal", result, 32'h1234_5678);
        run_op("mul_zero", 2'd0, 32'h8000_0000, 32'd2, 1'b0, 1'b0);

        // Re-pulsed start ignored; the cycle-34 start is accepted.
        run_op("ignore_start", 2'd2, 32'd1000, 32'd33, 1'b0, 1'b1);
        run_op("accept_c34", 2'd0, 32'd123, 32'd456, 1'b0, 1'b0);

        // Reset in cycle 10 of a DIVU aborts it; first cycle after release accepts.
        start = 1'b1;
        oper  = 2'd2;
        srcA  = 32'd5000;
        srcB  = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        check("abort zero", 32'(zero), 32'd1);
        rst_n = 1'b1;
        tick();
        run_op("mul3x3", 2'd0, 32'd3, 32'd3, 1'b0, 1'b0);
        check("mul3x3 literal", result, 32'd9);

        // Randomized operations with operands scrambled during RUN.
        for (int i = 0; i < 20; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
